high_freq_fir: RTL and testbench

HIGH_FREQ_FIR -- requirements
Module: high_freq_fir

---
 rtl/high_freq_fir.sv | 120 ++++++++++++
 tb/tb_high_freq_fir.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/high_freq_fir.sv
// Stereo FIR MAC: one shared Q1.15 coefficient stream, 1021 taps, 42-bit accumulators.
// Define FIR_SAT_EN to saturate results to 16 bits; otherwise accumulator bits [30:15] wrap.
module high_freq_fir (
  input  logic               clk,
  input  logic               rst,
  input  logic               sequencing,
  input  logic signed [15:0] lft_in,
  input  logic signed [15:0] rght_in,
  output logic        [9:0]  coeff_addr,
  input  logic signed [15:0] coeff,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               valid
);

  localparam logic [10:0] NUM_TAPS = 11'd1021;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [10:0]        tap_cnt;
  logic               tap_ok;
  logic               seq_d, seq_dd, acc_en;
  logic               first_tap, out_load;
  logic signed [31:0] lft_prod, rght_prod;
  logic signed [41:0] lft_acc, rght_acc;
  logic signed [41:0] lft_ext, rght_ext;
  logic signed [15:0] lft_nar, rght_nar;

  // Samples and coefficients both arrive one cycle after the address, so the
  // registered gate acc_en lines up with the data it qualifies.
  assign tap_ok     = sequencing && (tap_cnt < NUM_TAPS);
  assign coeff_addr = tap_ok ? tap_cnt[9:0] : 10'd0;
  assign first_tap  = seq_d && !seq_dd;
  assign out_load   = (state == ACCUM) && !seq_d;

  assign lft_prod  = 32'(lft_in) * 32'(coeff);
  assign rght_prod = 32'(rght_in) * 32'(coeff);
  assign lft_ext   = {{10{lft_prod[31]}}, lft_prod};
  assign rght_ext  = {{10{rght_prod[31]}}, rght_prod};

`ifdef FIR_SAT_EN
  function automatic logic signed [15:0] sat16(input logic signed [41:0] s);
    if (s > 42'sd32767)
      return 16'sh7FFF;
    else if (s < -42'sd32768)
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

  assign lft_nar  = sat16(lft_acc >>> 15);
  assign rght_nar = sat16(rght_acc >>> 15);
`else
  assign lft_nar  = lft_acc[30:15];
  assign rght_nar = rght_acc[30:15];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (seq_d) state_nxt = ACCUM;
      ACCUM:   if (!seq_d) state_nxt = OUTPUT;
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tap_cnt <= 11'd0;
      seq_d   <= 1'b0;
      seq_dd  <= 1'b0;
      acc_en  <= 1'b0;
    end else begin
      state  <= state_nxt;
      seq_d  <= sequencing;
      seq_dd <= seq_d;
      acc_en <= tap_ok;
      if (!sequencing)
        tap_cnt <= 11'd0;
      else if (tap_cnt < NUM_TAPS)
        tap_cnt <= tap_cnt + 11'd1;
    end
  end

  // A rising seq_d restarts the sums, so a burst starting during OUTPUT loses nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_acc  <= 42'sd0;
      rght_acc <= 42'sd0;
    end else if (acc_en) begin
      if (first_tap) begin
        lft_acc  <= lft_ext;
        rght_acc <= rght_ext;
      end else begin
        lft_acc  <= lft_acc + lft_ext;
        rght_acc <= rght_acc + rght_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_out  <= 16'sd0;
      rght_out <= 16'sd0;
      valid    <= 1'b0;
    end else begin
      valid <= out_load;
      if (out_load) begin
        lft_out  <= lft_nar;
        rght_out <= rght_nar;
      end
    end
  end

endmodule

// File: tb/tb_high_freq_fir.sv
// Directed bench for high_freq_fir: ROM and upstream queue models plus a reference MAC.
// Expected overflow value follows FIR_SAT_EN the same way the design does.
module tb_high_freq_fir;

  logic        clk = 1'b0;
  logic        rst;
  logic        sequencing;
  logic [15:0] lft_in, rght_in, coeff;
  logic [9:0]  coeff_addr;
  logic [15:0] lft_out, rght_out;
  logic        valid;

  logic [15:0] rom   [0:1023];
  logic [15:0] lsamp [0:1199];
  logic [15:0] rsamp [0:1199];

  int          cyc = 0;
  int          passCount = 0;
  int          checkCount = 0;
  int          vCount = 0;
  int          vCyc [0:3];
  logic [15:0] capL [0:3];
  logic [15:0] capR [0:3];
  logic [9:0]  maxAddr = 10'd0;
  int          tapIdx = 0;
  int          pendIdx = 0;
  logic        pend = 1'b0;
  int          lastSeq = 0;

`ifdef FIR_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h7806;
`endif

  high_freq_fir dut (
    .clk        (clk),
    .rst        (rst),
    .sequencing (sequencing),
    .lft_in     (lft_in),
    .rght_in    (rght_in),
    .coeff_addr (coeff_addr),
    .coeff      (coeff),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // External coefficient ROM with one cycle of read latency.
  always @(posedge clk) coeff <= rom[coeff_addr];

  always @(negedge clk) begin
    if (coeff_addr > maxAddr) maxAddr = coeff_addr;
    if (valid) begin
      if (vCount < 4) begin
        vCyc[vCount] = cyc;
        capL[vCount] = lft_out;
        capR[vCount] = rght_out;
      end
      vCount++;
    end
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // One clock of upstream traffic: present last cycle's sample, then set sequencing.
  task automatic applyStimulus(input logic s);
    @(posedge clk);
    #1;
    if (pend) begin
      lft_in  = lsamp[pendIdx];
      rght_in = rsamp[pendIdx];
    end else begin
      lft_in  = 16'h0;
      rght_in = 16'h0;
    end
    sequencing = s;
    if (s) begin
      pend    = 1'b1;
      pendIdx = tapIdx;
      tapIdx++;
      lastSeq = cyc;
    end else begin
      pend   = 1'b0;
      tapIdx = 0;
    end
  endtask

  function automatic logic [15:0] expOut(input int n, input bit right);
    longint acc;
    longint sh;
    int     m;
    acc = 0;
    m = (n < 1021) ? n : 1021;
    for (int k = 0; k < m; k++)
      acc += longint'($signed(right ? rsamp[k] : lsamp[k])) * longint'($signed(rom[k]));
`ifdef FIR_SAT_EN
    sh = acc >>> 15;
    if (sh > 32767) return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
    return sh[15:0];
`else
    sh = acc;
    return sh[30:15];
`endif
  endfunction

  // valid is expected in the third cycle after the last sequencing cycle.
  task automatic runBurst(input int n, input string tag, input logic [15:0] expL, input logic [15:0] expR);
    int endSeq;
    vCount  = 0;
    vCyc[0] = -100;
    maxAddr = 10'd0;
    for (int k = 0; k < n; k++) applyStimulus(1'b1);
    endSeq = lastSeq;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0);
    checkOutput({tag, " pulses"}, vCount, 1);
    checkOutput({tag, " latency"}, vCyc[0] - endSeq, 3);
    checkOutput({tag, " lft"}, capL[0], expL);
    checkOutput({tag, " rght"}, capR[0], expR);
    checkOutput({tag, " hold"}, lft_out, expL);
  endtask

  task automatic resetMidBurst();
    vCount = 0;
    for (int k = 0; k < 500; k++) applyStimulus(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sequencing = 1'b0;
    lft_in = 16'h0;
    rght_in = 16'h0;
    pend = 1'b0;
    tapIdx = 0;
    #1;
    checkOutput("rst async lft", lft_out, 0);
    checkOutput("rst async rght", rght_out, 0);
    checkOutput("rst addr", coeff_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0);
    checkOutput("rst no pulse", vCount, 0);
  endtask

  task automatic backToBack(input int n1, input int n2);
    int end1, end2;
    vCount  = 0;
    vCyc[0] = -100;
    vCyc[1] = -100;
    for (int k = 0; k < n1; k++) applyStimulus(1'b1);
    end1 = lastSeq;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int k = 0; k < n2; k++) applyStimulus(1'b1);
    end2 = lastSeq;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0);
    checkOutput("b2b start in OUTPUT", (end2 - n2 + 1) - end1, 3);
    checkOutput("b2b pulses", vCount, 2);
    checkOutput("b2b latency1", vCyc[0] - end1, 3);
    checkOutput("b2b latency2", vCyc[1] - end2, 3);
    checkOutput("b2b lft1", capL[0], expOut(n1, 1'b0));
    checkOutput("b2b rght1", capR[0], expOut(n1, 1'b1));
    checkOutput("b2b lft2", capL[1], expOut(n2, 1'b0));
    checkOutput("b2b rght2", capR[1], expOut(n2, 1'b1));
  endtask

  initial begin
    rst = 1'b1;
    sequencing = 1'b0;
    lft_in = 16'h0;
    rght_in = 16'h0;
    for (int k = 0; k < 1024; k++) rom[k] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid", valid, 0);
    checkOutput("reset lft", lft_out, 0);
    checkOutput("reset rght", rght_out, 0);
    checkOutput("reset addr", coeff_addr, 0);
    rst = 1'b0;

    for (int k = 0; k < 1200; k++) begin
      lsamp[k] = 16'($urandom);
      rsamp[k] = 16'($urandom);
    end
    for (int k = 0; k < 1024; k++) rom[k] = 16'h0;
    rom[0]   = 16'h7FFF;
    lsamp[0] = 16'h4000;
    rsamp[0] = 16'hC000;
    // 0x7FFF * -0x4000 >>> 15 = -16383.5, floor -16384
    runBurst(1021, "impulse", 16'h3FFF, 16'hC000);

    for (int k = 0; k < 1200; k++) begin
      lsamp[k] = 16'h0100;
      rsamp[k] = 16'h0100;
    end
    for (int k = 0; k < 1024; k++) rom[k] = 16'h0100;
    runBurst(1021, "sum", 16'h07FA, 16'h07FA);

    for (int k = 0; k < 1200; k++) begin
      lsamp[k] = 16'h7FFF;
      rsamp[k] = 16'h7FFF;
    end
    for (int k = 0; k < 1024; k++) rom[k] = 16'h7FFF;
    runBurst(1021, "overflow", OVF_EXP, OVF_EXP);

    for (int k = 0; k < 1200; k++) begin
      lsamp[k] = 16'($urandom);
      rsamp[k] = 16'($urandom);
    end
    for (int k = 0; k < 1024; k++) rom[k] = 16'($urandom);
    runBurst(1021, "full", expOut(1021, 1'b0), expOut(1021, 1'b1));
    runBurst(1100, "long", expOut(1021, 1'b0), expOut(1021, 1'b1));
    checkOutput("long max addr", maxAddr, 1020);
    runBurst(10, "short", expOut(10, 1'b0), expOut(10, 1'b1));

    resetMidBurst();
    runBurst(1021, "after reset", expOut(1021, 1'b0), expOut(1021, 1'b1));

    backToBack(1021, 10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
